// File: rtl/assoc_fill_pkg.sv
// Shared types for the associative-buffer miss-handling controller.
package assoc_fill_pkg;

    localparam int unsigned STAT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        RESP
    } fill_state_e;

endpackage

// File: rtl/assoc_fill_stats.sv
// Saturating hit/miss counter pair, sampled once per lookup.
module assoc_fill_stats
    import assoc_fill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup,
    input  logic                  hit,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (lookup) begin
            if (hit && (hit_count != '1)) begin
                hit_count <= hit_count + STAT_WIDTH'(1);
            end
            if (!hit && (miss_count != '1)) begin
                miss_count <= miss_count + STAT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/assoc_fill_ctrl.sv
// Miss-handling controller for a small fully associative buffer bank.
// Optional hit/miss statistics are enabled with ASSOC_FILL_STATS_EN.
module assoc_fill_ctrl
    import assoc_fill_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_hit,
    output logic [ADDR_WIDTH-1:0] bank_raddr,
    input  logic [DATA_WIDTH-1:0] bank_rdata,
    input  logic                  bank_hit,
    output logic                  bank_we,
    output logic [ADDR_WIDTH-1:0] bank_waddr,
    output logic [DATA_WIDTH-1:0] bank_wdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
`ifdef ASSOC_FILL_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
`endif
);

    fill_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  hit_q, hit_d;

    // State and holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state and per-state output decode; anything not driven by a state is 0.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        fill_d        = fill_q;
        data_d        = data_q;
        hit_d         = hit_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        resp_hit      = 1'b0;
        bank_raddr    = '0;
        bank_we       = 1'b0;
        bank_waddr    = '0;
        bank_wdata    = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;

        unique case (state_q)
            IDLE: begin
                req_ready  = 1'b1;
                bank_raddr = req_addr;
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                bank_raddr = addr_q;
                if (bank_hit) begin
                    data_d  = bank_rdata;
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q;
                if (mem_req_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    fill_d  = mem_resp_data;
                    data_d  = mem_resp_data;
                    hit_d   = 1'b0;
                    state_d = FILL;
                end
            end
            FILL: begin
                bank_we    = 1'b1;
                bank_waddr = addr_q;
                bank_wdata = fill_q;
                state_d    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = data_q;
                resp_hit   = hit_q;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef ASSOC_FILL_STATS_EN
    assoc_fill_stats u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup     (state_q == LOOKUP),
        .hit        (bank_hit),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`endif

endmodule
